fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset (word-aligned).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 redirect  input  1  taken branch / PC write from the conditional logic; one-cycle pulse.
REQ-005 redirect_pc  input  32  new fetch address, valid when redirect=1; bits [1:0] ignored, treated as 00.
REQ-006 imem_req  output  1  instruction memory read request, one-cycle pulse.
REQ-007 imem_addr  output  32  word-aligned read address, valid when imem_req=1.
REQ-008 imem_rvalid  input  1  read data valid; earliest one cycle after imem_req; at most one response per request.
REQ-009 imem_rdata  input  32  instruction word, valid when imem_rvalid=1.
REQ-010 instr_valid  output  1  instr/instr_pc hold an instruction for the decoder.
REQ-011 instr_ready  input  1  decoder accepts the instruction this cycle.
REQ-012 instr  output  32  held instruction word.
REQ-013 instr_pc  output  32  address of the held instruction.
REQ-014 pc_plus8  output  32  instr_pc + 8 (architectural PC read value), combinational.
REQ-015 cond, op, funct, rd  output  4/2/6/4  combinational slices instr[31:28], instr[27:26], instr[25:20], instr[15:12] for the decoder.

Function
REQ-016 FSM states: IDLE, FETCH, WAIT, HOLD; one outstanding memory request maximum.
REQ-017 IDLE: no request; next state FETCH unconditionally.
REQ-018 FETCH: imem_req=1, imem_addr=pc for exactly one cycle; next state WAIT.
REQ-019 WAIT, imem_rvalid=1, kill=0, redirect=0: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, next HOLD.
REQ-020 HOLD: instr_valid=1; instr and instr_pc stable until handshake; instr_valid & instr_ready -> next FETCH, instr_valid deasserted next cycle.
REQ-021 Minimum fetch-to-valid latency: 2 cycles after the imem_req cycle when rvalid arrives one cycle after the request; maximum throughput one instruction per 3 cycles.
REQ-022 pc+4 arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-023 imem_req, instr_valid are 0 in IDLE and WAIT; imem_rvalid outside WAIT is ignored.
REQ-024 Redirect in FETCH: request still issues at old pc; pc<=redirect_pc, kill<=1, next WAIT.
REQ-025 Redirect in WAIT without rvalid: pc<=redirect_pc, kill<=1, stay WAIT; later redirects overwrite pc.
REQ-026 Redirect in WAIT coincident with rvalid: response dropped, pc<=redirect_pc, kill<=0, next FETCH.
REQ-027 WAIT, rvalid=1, kill=1: response dropped, kill<=0, next FETCH (fetches the redirected pc).
REQ-028 Redirect in HOLD: held instruction discarded (with or without coincident handshake), pc<=redirect_pc, instr_valid=0 next cycle, next FETCH.
REQ-029 Redirect in IDLE: pc<=redirect_pc, next FETCH.
REQ-030 A dropped response never updates instr, instr_pc, or asserts instr_valid.

Reset
REQ-031 reset=1 at a clock edge: state<=IDLE, pc<=RESET_PC, kill<=0, instr<=0, instr_pc<=0 regardless of current state (including mid-WAIT).
REQ-032 During and in the cycle after reset: imem_req=0, instr_valid=0; first imem_req in the second cycle after reset deasserts.
REQ-033 reset has priority over redirect and imem_rvalid.

Verification
REQ-034 Reset release, RESET_PC=0, rvalid 1 cycle after req with 32'hE081_2003, ready=1 -> imem_addr=0; instr_valid with instr=32'hE081_2003, instr_pc=0, pc_plus8=8, op=00, funct=6'b001000, rd=2; next imem_addr=4.
REQ-035 instr_ready=0 for 5 cycles in HOLD -> instr_valid stays 1, instr unchanged, no imem_req; ready=1 -> fetch of next address.
REQ-036 Redirect to 32'h0000_0103 while WAIT, rvalid 3 cycles later -> response dropped, instr_valid stays 0, next imem_addr=32'h0000_0100.
REQ-037 Redirect to 32'h40 coincident with rvalid -> no instr_valid; next imem_addr=32'h40.
REQ-038 pc=32'hFFFF_FFFC fetched and accepted -> next imem_addr=32'h0000_0000.
REQ-039 reset asserted mid-WAIT, stale rvalid during IDLE -> ignored, instr_valid=0, next imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fetch_unit : single-outstanding instruction fetch FSM with redirect    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rd
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

  // pc only changes on leaving FETCH, so it is the request address for the whole FETCH cycle
  assign imem_addr = pc;
  assign pc_plus8  = instr_pc + 32'd8;
  assign cond      = instr[31:28];
  assign op        = instr[27:26];
  assign funct     = instr[25:20];
  assign rd        = instr[15:12];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (redirect) pc <= redirect_pc_aligned;
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          // the request for the old pc is already out; kill marks its response stale
          if (redirect) begin
            pc   <= redirect_pc_aligned;
            kill <= 1'b1;
          end
          state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (redirect) begin
              pc       <= redirect_pc_aligned;
              kill     <= 1'b0;
              state    <= FETCH;
              imem_req <= 1'b1;
            end else if (kill) begin
              kill     <= 1'b0;
              state    <= FETCH;
              imem_req <= 1'b1;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              pc          <= pc + 32'd4;
              state       <= HOLD;
              instr_valid <= 1'b1;
            end
          end else if (redirect) begin
            pc   <= redirect_pc_aligned;
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect || instr_ready) begin
            if (redirect) pc <= redirect_pc_aligned;
            state    <= FETCH;
            imem_req <= 1'b1;
          end else begin
            instr_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus8;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .pc_plus8(pc_plus8),
    .cond(cond), .op(op), .funct(funct), .rd(rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
    tick(); tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // first cycle after reset: still idle
    reset = 1'b0;
    check("post_rst_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0000_0000);

    // basic fetch with one-cycle memory latency
    tick();
    check("wait_req", {31'd0, imem_req}, 32'd0);
    check("wait_valid", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hE081_2003;
    tick();
    imem_rvalid = 1'b0;
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_instr", instr, 32'hE081_2003);
    check("hold_instr_pc", instr_pc, 32'h0);
    check("hold_pc_plus8", pc_plus8, 32'h8);
    check("hold_cond", {28'd0, cond}, 32'hE);
    check("hold_op", {30'd0, op}, 32'd0);
    check("hold_funct", {26'd0, funct}, 32'h08);
    check("hold_rd", {28'd0, rd}, 32'd2);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("next_valid", {31'd0, instr_valid}, 32'd0);
    check("next_req", {31'd0, imem_req}, 32'd1);
    check("next_addr", imem_addr, 32'h4);

    // decoder stall for 5 cycles in HOLD
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_instr", instr, 32'h1111_1111);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      tick();
    end
    check("stall_instr_pc", instr_pc, 32'h4);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("stall_release_req", {31'd0, imem_req}, 32'd1);
    check("stall_release_addr", imem_addr, 32'h8);

    // redirect in WAIT without rvalid; late response must be dropped
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    tick(); tick();
    check("kill_wait_valid", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("kill_drop_valid", {31'd0, instr_valid}, 32'd0);
    check("kill_instr_kept", instr, 32'h1111_1111);
    check("kill_req", {31'd0, imem_req}, 32'd1);
    check("kill_addr", imem_addr, 32'h0000_0100);

    // redirect coincident with rvalid
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    imem_rvalid = 1'b0; redirect = 1'b0;
    check("coinc_valid", {31'd0, instr_valid}, 32'd0);
    check("coinc_req", {31'd0, imem_req}, 32'd1);
    check("coinc_addr", imem_addr, 32'h40);

    // redirect during FETCH: request at old pc, its response dropped
    redirect = 1'b1; redirect_pc = 32'h200;
    check("fetch_redir_addr", imem_addr, 32'h40);
    tick();
    redirect = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002;
    tick();
    imem_rvalid = 1'b0;
    check("fetch_redir_valid", {31'd0, instr_valid}, 32'd0);
    check("fetch_redir_addr2", imem_addr, 32'h200);

    // reset mid-WAIT, stale rvalid during IDLE
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0003;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_instr", instr, 32'd0);
    check("midrst_instr_pc", instr_pc, 32'd0);
    tick();
    imem_rvalid = 1'b0;
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_req2", {31'd0, imem_req}, 32'd1);
    check("midrst_addr", imem_addr, 32'h0);

    // redirect with coincident handshake in HOLD, then wrap at top of memory
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_rvalid = 1'b0;
    check("hold2_valid", {31'd0, instr_valid}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    check("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
    check("hold_redir_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    tick();
    imem_rvalid = 1'b0;
    check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus8", pc_plus8, 32'h4);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    check("wrap_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
